// File: rtl/johnson_phase_decoder_if.sv
// Purpose: bundles the Johnson code input, control strobes and decoded phase outputs.
// Latency: none, wiring only.
// Backpressure: none; the decoder consumes a code every cycle.
interface johnson_phase_decoder_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
);
    localparam int NPH   = 2 * WIDTH;
    localparam int IDX_W = $clog2(NPH);

    // Upstream side: code stream plus control strobes
    logic [WIDTH-1:0] count_in;
    logic             resync;
    logic             err_clr;

    // Decoder side: registered phase information and status
    logic             valid;
    logic [IDX_W-1:0] phase_idx;
    logic [NPH-1:0]   phase_onehot;
    logic             illegal;
    logic             seq_err;
    logic             rev_tick;
    logic [REV_W-1:0] rev_count;

    // Drives codes and strobes, observes decoded outputs
    modport master (
        output count_in, resync, err_clr,
        input  valid, phase_idx, phase_onehot, illegal, seq_err, rev_tick, rev_count
    );

    // The decoder itself
    modport slave (
        input  count_in, resync, err_clr,
        output valid, phase_idx, phase_onehot, illegal, seq_err, rev_tick, rev_count
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Purpose: decode Johnson codes to phase index/one-hot, police the sequence, count revolutions.
// Latency: 1 cycle, a code sampled at edge N appears on the outputs after edge N.
// Backpressure: none; every cycle's code is consumed, stalls show up as repeated codes.
module johnson_phase_decoder #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
) (
    input  logic                   clk,
    input  logic                   clear,
    johnson_phase_decoder_if.slave bus
);
    localparam int NPH   = 2 * WIDTH;
    localparam int IDX_W = $clog2(NPH);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPH - 1);

    typedef enum logic {
        SYNC  = 1'b0,   // no reference code yet, next legal code is taken as-is
        TRACK = 1'b1    // prev index held in phase_idx_q, steps are checked
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
    logic [NPH-1:0]   phase_onehot_q, phase_onehot_d;
    logic             illegal_q, illegal_d;
    logic             seq_err_q, seq_err_d;
    logic             rev_tick_q, rev_tick_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             resync_q;

    logic             code_legal;
    logic [IDX_W-1:0] code_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             err_set;

    // Johnson code for phase k: first W phases fill ones from the LSB,
    // the remaining phases drain them from the LSB again.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (k <= WIDTH) c[j] = (j < k);
            else            c[j] = (j >= k - WIDTH);
        end
        return c;
    endfunction

    function automatic logic [NPH-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        logic [NPH-1:0] o;
        o      = '0;
        o[idx] = 1'b1;
        return o;
    endfunction

    // Match the incoming code against every legal map entry
    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 0; k < NPH; k++) begin
            if (bus.count_in == code_of(k)) begin
                code_legal = 1'b1;
                code_idx   = IDX_W'(k);
            end
        end
    end

    // Expected successor of the held phase; 2W need not be a power of two
    always_comb begin
        succ_idx = (phase_idx_q == LAST_IDX) ? '0 : phase_idx_q + IDX_W'(1);
    end

    // Next-state and output decisions for the SYNC/TRACK tracker
    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        phase_idx_d    = phase_idx_q;
        phase_onehot_d = phase_onehot_q;
        illegal_d      = 1'b0;
        rev_tick_d     = 1'b0;
        rev_count_d    = rev_count_q;
        err_set        = 1'b0;

        if (!code_legal) begin
            // Any illegal code drops lock; phase_idx keeps its last value
            illegal_d      = 1'b1;
            err_set        = 1'b1;
            valid_d        = 1'b0;
            phase_onehot_d = '0;
            state_d        = SYNC;
        end else if (state_q == SYNC) begin
            // First legal code becomes the reference, nothing to compare against
            state_d        = TRACK;
            valid_d        = 1'b1;
            phase_idx_d    = code_idx;
            phase_onehot_d = onehot_of(code_idx);
        end else if (code_idx == phase_idx_q) begin
            // Upstream held its value: nothing changes
            valid_d = 1'b1;
        end else begin
            // Any other legal code is accepted; only its legitimacy differs
            valid_d        = 1'b1;
            phase_idx_d    = code_idx;
            phase_onehot_d = onehot_of(code_idx);
            if (code_idx == succ_idx) begin
                if (phase_idx_q == LAST_IDX) begin
                    rev_tick_d  = 1'b1;
                    rev_count_d = rev_count_q + REV_W'(1);
                end
            end else if (!(bus.resync || resync_q)) begin
                // Unannounced jump: flag it but re-anchor on the new phase
                err_set = 1'b1;
            end
        end

        // Sticky error: a new error beats a simultaneous clear request
        if (err_set)          seq_err_d = 1'b1;
        else if (bus.err_clr) seq_err_d = 1'b0;
        else                  seq_err_d = seq_err_q;
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q        <= SYNC;
            valid_q        <= 1'b0;
            phase_idx_q    <= '0;
            phase_onehot_q <= '0;
            illegal_q      <= 1'b0;
            seq_err_q      <= 1'b0;
            rev_tick_q     <= 1'b0;
            rev_count_q    <= '0;
            resync_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            phase_idx_q    <= phase_idx_d;
            phase_onehot_q <= phase_onehot_d;
            illegal_q      <= illegal_d;
            seq_err_q      <= seq_err_d;
            rev_tick_q     <= rev_tick_d;
            rev_count_q    <= rev_count_d;
            resync_q       <= bus.resync;
        end
    end

    assign bus.valid        = valid_q;
    assign bus.phase_idx    = phase_idx_q;
    assign bus.phase_onehot = phase_onehot_q;
    assign bus.illegal      = illegal_q;
    assign bus.seq_err      = seq_err_q;
    assign bus.rev_tick     = rev_tick_q;
    assign bus.rev_count    = rev_count_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Purpose: directed checks of johnson_phase_decoder decode, sequence policing and revolutions.
// Latency: expects results one clock after each applied code.
// Backpressure: none; one code applied per clock.
module tb_johnson_phase_decoder;
    logic clk;
    logic clear;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_phase_decoder_if #(.WIDTH(4), .REV_W(8)) jif ();

    johnson_phase_decoder #(.WIDTH(4), .REV_W(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (jif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, report it if it mismatches
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one code and strobes, then advance to just past the next edge
    task automatic step(input logic [3:0] c, input logic rs, input logic ec);
        jif.count_in = c;
        jif.resync   = rs;
        jif.err_clr  = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_phase(input string tag, input int idx);
        chk({tag, ".valid"},  32'(jif.valid), 32'd1);
        chk({tag, ".idx"},    32'(jif.phase_idx), 32'(idx));
        chk({tag, ".onehot"}, 32'(jif.phase_onehot), 32'(1 << idx));
    endtask

    initial begin
        // 1: reset with an illegal code present
        clear = 1'b0;
        step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        chk("rst.valid",   32'(jif.valid), 32'd0);
        chk("rst.idx",     32'(jif.phase_idx), 32'd0);
        chk("rst.onehot",  32'(jif.phase_onehot), 32'd0);
        chk("rst.illegal", 32'(jif.illegal), 32'd0);
        chk("rst.seq_err", 32'(jif.seq_err), 32'd0);
        chk("rst.rev_tick",32'(jif.rev_tick), 32'd0);
        chk("rst.rev_cnt", 32'(jif.rev_count), 32'd0);

        // 2: free run through one full revolution
        clear = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(codes[k], 1'b0, 1'b0);
            chk_phase($sformatf("run%0d", k), k);
            chk($sformatf("run%0d.tick", k), 32'(jif.rev_tick), 32'd0);
        end
        step(4'b0000, 1'b0, 1'b0);
        chk_phase("wrap", 0);
        chk("wrap.tick",    32'(jif.rev_tick), 32'd1);
        chk("wrap.rev_cnt", 32'(jif.rev_count), 32'd1);
        chk("wrap.seq_err", 32'(jif.seq_err), 32'd0);

        // 3: hold at 0011 for 5 cycles
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0011, 1'b0, 1'b0);
            chk_phase($sformatf("hold%0d", i), 2);
            chk($sformatf("hold%0d.err", i), 32'(jif.seq_err), 32'd0);
        end

        // 4: announced preset jump 1 -> 7 then wrap
        for (int k = 3; k < 8; k++) step(codes[k], 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("lap2.rev_cnt", 32'(jif.rev_count), 32'd2);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        chk_phase("pre", 7);
        chk("pre.seq_err", 32'(jif.seq_err), 32'd0);
        chk("pre.tick",    32'(jif.rev_tick), 32'd0);
        step(4'b0000, 1'b0, 1'b0);
        chk("pre.wrap_tick", 32'(jif.rev_tick), 32'd1);
        chk("pre.rev_cnt",   32'(jif.rev_count), 32'd3);
        // same jump without resync
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        chk_phase("jmp", 7);
        chk("jmp.seq_err", 32'(jif.seq_err), 32'd1);
        chk("jmp.tick",    32'(jif.rev_tick), 32'd0);
        chk("jmp.rev_cnt", 32'(jif.rev_count), 32'd3);
        step(4'b0000, 1'b0, 1'b0);
        chk("jmp.wrap_tick", 32'(jif.rev_tick), 32'd1);
        chk("jmp.rev_cnt2",  32'(jif.rev_count), 32'd4);

        // 5: err_clr alone, then illegal code while tracking
        step(4'b0001, 1'b0, 1'b1);
        chk("eclr.seq_err", 32'(jif.seq_err), 32'd0);
        step(4'b0101, 1'b0, 1'b0);
        chk("ill.illegal", 32'(jif.illegal), 32'd1);
        chk("ill.valid",   32'(jif.valid), 32'd0);
        chk("ill.onehot",  32'(jif.phase_onehot), 32'd0);
        chk("ill.idx",     32'(jif.phase_idx), 32'd1);
        chk("ill.seq_err", 32'(jif.seq_err), 32'd1);
        step(4'b0011, 1'b0, 1'b0);
        chk_phase("resync_in", 2);
        chk("resync_in.illegal", 32'(jif.illegal), 32'd0);
        chk("resync_in.seq_err", 32'(jif.seq_err), 32'd1);

        // 6: illegal with err_clr keeps error; err_clr alone clears
        step(4'b0101, 1'b0, 1'b1);
        chk("both.seq_err", 32'(jif.seq_err), 32'd1);
        chk("both.illegal", 32'(jif.illegal), 32'd1);
        step(4'b0011, 1'b0, 1'b1);
        chk("clr2.seq_err", 32'(jif.seq_err), 32'd0);
        chk_phase("clr2", 2);
        // clear mid-revolution at idx 5
        step(4'b0111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1110, 1'b0, 1'b0);
        chk_phase("mid", 5);
        clear = 1'b0;
        step(4'b1100, 1'b0, 1'b0);
        chk("mclr.valid",   32'(jif.valid), 32'd0);
        chk("mclr.idx",     32'(jif.phase_idx), 32'd0);
        chk("mclr.onehot",  32'(jif.phase_onehot), 32'd0);
        chk("mclr.rev_cnt", 32'(jif.rev_count), 32'd0);
        chk("mclr.seq_err", 32'(jif.seq_err), 32'd0);
        clear = 1'b1;
        step(4'b1100, 1'b0, 1'b0);
        chk_phase("after", 6);
        // resync in the previous cycle also excuses a jump
        step(4'b1100, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        chk_phase("rsq", 1);
        chk("rsq.seq_err", 32'(jif.seq_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
